// File: rtl/data_ram_sync_pkg.sv
// Shared encodings for the synchronous-read data RAM: request strobes, reset
// polarity and the clear/ready sequencer states.
package data_ram_sync_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [0:0] {
        RAM_STATE_CLEAR = 1'b0,
        RAM_STATE_READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/data_ram_lane.sv
// One byte-wide lane of the data RAM: synchronous write, asynchronous index read
// (the top registers the read word, giving the one-cycle read latency).
module data_ram_lane #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem_r [DEPTH];

    // Byte storage; contents are only changed by explicit writes
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/data_ram_sync.sv
// Synchronous-read data memory for the MEM stage: byte-lane writes, registered
// reads with valid/error strobes, and a post-reset clear sequencer.
module data_ram_sync
    import data_ram_sync_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DEPTH          = 512,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'h0000_0000),
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    rvalid_o,
    output logic                    err_o,
    output logic                    busy_o
);

    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int IDX_BITS  = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(DEPTH * LANES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(LANES - 1);
    localparam logic [IDX_BITS-1:0]   CNT_LAST  = IDX_BITS'(DEPTH - 1);
    localparam ram_state_e RESET_STATE =
        (CLEAR_ON_RESET != 0) ? RAM_STATE_CLEAR : RAM_STATE_READY;

    ram_state_e                state_r;
    logic [IDX_BITS-1:0]       cnt_r;
    logic [DATA_WIDTH-1:0]     data_r;
    logic                      rvalid_r;
    logic                      err_r;

    logic [ADDR_WIDTH-1:0]     off_s;
    logic                      bad_s;
    logic [IDX_BITS-1:0]       idx_s;
    logic [LANES-1:0]          lane_we_s;
    logic [IDX_BITS-1:0]       lane_idx_s;
    logic [DATA_WIDTH-1:0]     lane_wdata_s;
    logic [LANES-1:0][7:0]     rd_lanes_s;

    // Address decode; the below-base test is explicit so wrap-around never hides it
    always_comb begin
        off_s = addr - BASE_ADDR;
        bad_s = (addr < BASE_ADDR) || (off_s >= SPAN) || ((off_s & LANE_MASK) != '0);
        idx_s = IDX_BITS'(off_s >> LANE_BITS);
    end

    // Lane write port: the clear sequencer owns the array while busy
    always_comb begin
        lane_we_s    = '0;
        lane_idx_s   = idx_s;
        lane_wdata_s = data_i;
        if (rst == RST_ENABLE) begin
            lane_we_s = '0;
        end else if (state_r == RAM_STATE_CLEAR) begin
            lane_we_s    = '1;
            lane_idx_s   = cnt_r;
            lane_wdata_s = '0;
        end else if ((ce == CHIP_ENABLE) && (we == WRITE_ENABLE) && !bad_s) begin
            lane_we_s = sel;
        end else begin
            lane_we_s = '0;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        data_ram_lane #(
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we_s[g]),
            .idx   (lane_idx_s),
            .wdata (lane_wdata_s[g*8 +: 8]),
            .rdata (rd_lanes_s[g])
        );
    end

    // Sequencer state, clear counter and response registers
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r  <= RESET_STATE;
            cnt_r    <= '0;
            data_r   <= '0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            case (state_r)
                RAM_STATE_CLEAR: begin
                    err_r <= (ce == CHIP_ENABLE);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= RAM_STATE_READY;
                    end else begin
                        cnt_r <= cnt_r + IDX_BITS'(1'b1);
                    end
                end
                RAM_STATE_READY: begin
                    if (ce == CHIP_DISABLE) begin
                        err_r <= 1'b0;
                    end else if (we == WRITE_DISABLE) begin
                        // Rejected reads still answer (with zero) so the pipeline never waits forever
                        rvalid_r <= 1'b1;
                        err_r    <= bad_s;
                        data_r   <= bad_s ? '0 : DATA_WIDTH'(rd_lanes_s);
                    end else begin
                        err_r <= bad_s;
                    end
                end
                default: begin
                    state_r <= RESET_STATE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign data_o   = data_r;
    assign rvalid_o = rvalid_r;
    assign err_o    = err_r;
    assign busy_o   = (state_r == RAM_STATE_CLEAR);

endmodule

// File: tb/tb_data_ram_sync.sv
// Directed bench for data_ram_sync: a word-level model checks the default
// configuration every cycle; literal expectations pin both configurations.
module tb_data_ram_sync;

    logic        clk;
    int          total = 0;
    int          bad   = 0;

    // Default configuration: 32-bit, 512 words, base 0
    logic        a_rst, a_ce, a_we;
    logic [3:0]  a_sel;
    logic [31:0] a_addr, a_data_i, a_data_o;
    logic        a_rvalid, a_err, a_busy;

    // Wide configuration: 64-bit, 256 words, base 0x1000
    logic        b_rst, b_ce, b_we;
    logic [7:0]  b_sel;
    logic [31:0] b_addr;
    logic [63:0] b_data_i, b_data_o;
    logic        b_rvalid, b_err, b_busy;

    data_ram_sync u_dut_a (
        .clk(clk), .rst(a_rst), .ce(a_ce), .we(a_we), .sel(a_sel), .addr(a_addr),
        .data_i(a_data_i), .data_o(a_data_o), .rvalid_o(a_rvalid), .err_o(a_err), .busy_o(a_busy)
    );

    data_ram_sync #(
        .DATA_WIDTH(64), .DEPTH(256), .ADDR_WIDTH(32), .BASE_ADDR(32'h0000_1000), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .ce(b_ce), .we(b_we), .sel(b_sel), .addr(b_addr),
        .data_i(b_data_i), .data_o(b_data_o), .rvalid_o(b_rvalid), .err_o(b_err), .busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of configuration A: byte array, countdown of busy cycles, next-cycle response
    logic [7:0]  m_mem [2048];
    int          m_left;
    logic [31:0] m_data;
    logic        m_rv, m_err;
    logic        chk_a = 1'b0;

    function automatic logic m_good(input logic [31:0] ad);
        return (ad < 32'd2048) && (ad % 32'd4 == 32'd0);
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] ad);
        return {m_mem[ad + 32'd3], m_mem[ad + 32'd2], m_mem[ad + 32'd1], m_mem[ad]};
    endfunction

    always @(posedge clk) begin
        if (a_rst) begin
            for (int i = 0; i < 2048; i++) m_mem[i] <= 8'h00;
            m_left <= 512;
            m_data <= 32'h0;
            m_rv   <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_rv  <= 1'b0;
            m_err <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                m_err  <= a_ce;
            end else if (a_ce && !a_we) begin
                m_rv   <= 1'b1;
                m_err  <= !m_good(a_addr);
                m_data <= m_good(a_addr) ? m_word(a_addr) : 32'h0;
            end else if (a_ce && a_we) begin
                m_err <= !m_good(a_addr);
                if (m_good(a_addr))
                    for (int b = 0; b < 4; b++)
                        if (a_sel[b]) m_mem[a_addr + b] <= a_data_i[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_a) begin
            check("a_data_model",   64'(a_data_o), 64'(m_data));
            check("a_rvalid_model", 64'(a_rvalid), 64'(m_rv));
            check("a_err_model",    64'(a_err),    64'(m_err));
            check("a_busy_model",   64'(a_busy),   64'(m_left != 0));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_req(input logic we, input logic [3:0] sel, input logic [31:0] ad, input logic [31:0] d);
        a_ce = 1'b1; a_we = we; a_sel = sel; a_addr = ad; a_data_i = d;
        step(1);
        a_ce = 1'b0;
    endtask

    task automatic b_req(input logic we, input logic [7:0] sel, input logic [31:0] ad, input logic [63:0] d);
        b_ce = 1'b1; b_we = we; b_sel = sel; b_addr = ad; b_data_i = d;
        step(1);
        b_ce = 1'b0;
    endtask

    task automatic a_expect(input string nm, input logic [31:0] d, input logic rv, input logic er);
        check({nm, "_data"},   64'(a_data_o), 64'(d));
        check({nm, "_rvalid"}, 64'(a_rvalid), 64'(rv));
        check({nm, "_err"},    64'(a_err),    64'(er));
    endtask

    task automatic a_busy_len(input string nm, input int exp);
        int n = 0;
        while (a_busy && n < 2000) begin
            step(1);
            n++;
        end
        check(nm, 64'(n), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        a_rst = 1'b1; a_ce = 1'b0; a_we = 1'b0; a_sel = 4'h0; a_addr = 32'h0; a_data_i = 32'h0;
        b_rst = 1'b1; b_ce = 1'b0; b_we = 1'b0; b_sel = 8'h0; b_addr = 32'h0; b_data_i = 64'h0;
        step(1);
        a_expect("reset", 32'h0, 1'b0, 1'b0);
        check("reset_busy", 64'(a_busy), 64'h1);
        a_rst = 1'b0;
        chk_a = 1'b1;
        a_busy_len("clear_len", 512);

        a_req(1'b0, 4'h0, 32'h0000_07FC, 32'h0);
        a_expect("read_last_cleared", 32'h0, 1'b1, 1'b0);
        a_req(1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF);
        a_expect("full_write", 32'h0, 1'b0, 1'b0);
        a_req(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        a_expect("read_after_write", 32'hDEAD_BEEF, 1'b1, 1'b0);
        a_req(1'b1, 4'b0101, 32'h0000_0010, 32'h1122_3344);
        a_req(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        a_expect("partial_write", 32'hDE22_BE44, 1'b1, 1'b0);
        a_req(1'b0, 4'h0, 32'h0000_0801, 32'h0);
        a_expect("misaligned_read", 32'h0, 1'b1, 1'b1);
        a_req(1'b0, 4'h0, 32'h0000_0800, 32'h0);
        a_expect("range_read", 32'h0, 1'b1, 1'b1);
        a_req(1'b1, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D);
        a_req(1'b1, 4'b1111, 32'h0000_0800, 32'h5555_AAAA);
        a_expect("range_write", 32'h0, 1'b0, 1'b1);
        a_req(1'b1, 4'b0000, 32'h0000_0000, 32'hFFFF_FFFF);
        a_expect("sel_zero_write", 32'h0, 1'b0, 1'b0);
        a_req(1'b0, 4'h0, 32'h0000_0000, 32'h0);
        a_expect("word0_intact", 32'hCAFE_F00D, 1'b1, 1'b0);
        step(1);
        a_expect("idle_hold", 32'hCAFE_F00D, 1'b0, 1'b0);
        a_req(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        a_expect("b2b_first", 32'hDE22_BE44, 1'b1, 1'b0);
        a_req(1'b0, 4'h0, 32'h0000_0000, 32'h0);
        a_expect("b2b_second", 32'hCAFE_F00D, 1'b1, 1'b0);

        // Reset again, poke during the clear, then restart the clear at cycle 100
        a_rst = 1'b1;
        step(1);
        a_rst = 1'b0;
        a_req(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        a_expect("busy_read", 32'h0, 1'b0, 1'b1);
        step(98);
        a_rst = 1'b1;
        step(1);
        a_rst = 1'b0;
        a_busy_len("restart_len", 512);
        a_req(1'b0, 4'h0, 32'h0000_0010, 32'h0);
        a_expect("recleared", 32'h0, 1'b1, 1'b0);

        // Wide configuration
        step(1);
        b_rst = 1'b0;
        check("b_busy_after_reset", 64'(b_busy), 64'h1);
        n = 0;
        while (b_busy && n < 1000) begin
            step(1);
            n++;
        end
        check("b_clear_len", 64'(n), 64'd256);
        b_req(1'b1, 8'h80, 32'h0000_1008, 64'hAB00_0000_0000_0000);
        check("b_write_err", 64'(b_err), 64'h0);
        b_req(1'b0, 8'h00, 32'h0000_1008, 64'h0);
        check("b_read_data", b_data_o, 64'hAB00_0000_0000_0000);
        check("b_read_rvalid", 64'(b_rvalid), 64'h1);
        b_req(1'b0, 8'h00, 32'h0000_0FF8, 64'h0);
        check("b_below_base_err", 64'(b_err), 64'h1);
        check("b_below_base_data", b_data_o, 64'h0);
        b_req(1'b0, 8'h00, 32'h0000_1800, 64'h0);
        check("b_above_range_err", 64'(b_err), 64'h1);
        b_req(1'b0, 8'h00, 32'h0000_1000, 64'h0);
        check("b_word0_data", b_data_o, 64'h0);
        check("b_word0_err", 64'(b_err), 64'h0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
